// File: rtl/dino_vga_pkg.sv
// ----------------------------------------------------------------------------
// dino_vga_pkg
//  Constants and types shared by the VGA ground-strip blocks.
//  Contents:
//   GROUND_W     width of the ground pattern and of the px_ground bus
//   POS_W        width of scroll_pos (holds 0..GROUND_W-1)
//   VGA_H_TOTAL  pixel clocks per line, including blanking
//   VGA_V_TOTAL  lines per frame, including blanking
//   state_e      frame scheduler FSM states
// ----------------------------------------------------------------------------
package dino_vga_pkg;

   localparam int GROUND_W    = 320;
   localparam int POS_W       = 9;
   localparam int VGA_H_TOTAL = 800;
   localparam int VGA_V_TOTAL = 525;

   typedef enum logic [1:0] {
      S_ACTIVE = 2'd0,
      S_UPD    = 2'd1,
      S_SHIFT  = 2'd2
   } state_e;

endpackage

// File: rtl/vga_frame_sched_if.sv
// ----------------------------------------------------------------------------
// vga_frame_sched_if
//  Per-frame update handshake between the frame scheduler and game logic.
//  Signals:
//   upd_req   scheduler -> game : update window open (level)
//   upd_done  game -> scheduler : frame update finished
//  Handshake: upd_req rises the cycle after a frame start and stays high until
//  upd_done is sampled high on a clock edge (or the wait times out); it drops
//  in the cycle following that edge. upd_done is only looked at while upd_req
//  is high; at any other time it is ignored.
//  Modports: master = scheduler side, slave = game logic side.
// ----------------------------------------------------------------------------
interface vga_frame_sched_if;

   logic upd_req;
   logic upd_done;

   modport master (output upd_req, input upd_done);
   modport slave  (input upd_req, output upd_done);

endinterface

// File: rtl/vga_ground_rot.sv
// ----------------------------------------------------------------------------
// vga_ground_rot
//  Ground pattern register with rotate-left-by-1, parallel load, and the
//  matching scroll position counter that wraps at GROUND_W.
//  Ports:
//   clk_i           clock
//   clr_i           synchronous active-high reset (pattern and position to 0)
//   load_i          replace the pattern with load_pattern_i, position to 0
//   load_pattern_i  new pattern
//   rot_i           rotate pattern left by one bit, advance position by one
//   px_o            current pattern
//   pos_o           total scroll modulo GROUND_W
// ----------------------------------------------------------------------------
module vga_ground_rot
   import dino_vga_pkg::*;
(
   input  logic                clk_i,
   input  logic                clr_i,
   input  logic                load_i,
   input  logic [GROUND_W-1:0] load_pattern_i,
   input  logic                rot_i,
   output logic [GROUND_W-1:0] px_o,
   output logic [POS_W-1:0]    pos_o
);

   logic [GROUND_W-1:0] px_q, px_d;
   logic [POS_W-1:0]    pos_q, pos_d;

   always_comb begin
      px_d  = px_q;
      pos_d = pos_q;
      if (load_i) begin
         px_d  = load_pattern_i;
         pos_d = '0;
      end else if (rot_i) begin
         px_d  = {px_q[GROUND_W-2:0], px_q[GROUND_W-1]};
         pos_d = (pos_q == POS_W'(GROUND_W - 1)) ? '0 : pos_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         px_q  <= '0;
         pos_q <= '0;
      end else begin
         px_q  <= px_d;
         pos_q <= pos_d;
      end
   end

   assign px_o  = px_q;
   assign pos_o = pos_q;

endmodule

// File: rtl/vga_frame_sched.sv
// ----------------------------------------------------------------------------
// vga_frame_sched
//  Per-frame scheduler for the VGA ground strip. A falling edge on vs marks a
//  frame start; the scheduler then opens one update window for game logic
//  (upd_req/upd_done) and afterwards scrolls the ground pattern left by the
//  frame's speed, one bit per cycle, all inside vertical blanking.
//  Optional build macro: DINO_SCROLL_ACCEL_EN adds a frame counter that raises
//  an internal speed offset by one every 256 frames (saturating at 15).
//  Ports:
//   vga_clk       pixel clock
//   clr           synchronous active-high reset
//   vs            vertical sync (low = sync pulse)
//   run           1 = scrolling enabled
//   speed         pixels scrolled per frame
//   load          strobe: replace the pattern (honoured only when idle)
//   load_pattern  new ground pattern
//   upd           update handshake (master side)
//   frame_tick    one-cycle pulse per detected frame start
//   px_ground     current ground pattern
//   scroll_pos    total scroll modulo GROUND_W
//   busy          scheduler not idle
//   err           sticky: update timeout or frame overrun
//   dbg_state_o   current FSM state
// ----------------------------------------------------------------------------
module vga_frame_sched
   import dino_vga_pkg::*;
#(
   parameter int TIMEOUT = 1024
)(
   input  logic                vga_clk,
   input  logic                clr,
   input  logic                vs,
   input  logic                run,
   input  logic [3:0]          speed,
   input  logic                load,
   input  logic [GROUND_W-1:0] load_pattern,
   vga_frame_sched_if.master   upd,
   output logic                frame_tick,
   output logic [GROUND_W-1:0] px_ground,
   output logic [POS_W-1:0]    scroll_pos,
   output logic                busy,
   output logic                err,
   output state_e              dbg_state_o
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_e           state_q, state_d;
   logic             vs_q;
   logic             frame_tick_q;
   logic             err_q, err_d;
   logic [CNT_W-1:0] wait_q, wait_d;
   logic [3:0]       shift_q, shift_d;
   logic             start;
   logic             rot_en;
   logic             load_ok;
   logic [3:0]       eff_spd;

   assign start   = vs_q & ~vs;
   assign load_ok = load & (state_q == S_ACTIVE);

`ifdef DINO_SCROLL_ACCEL_EN
   logic [7:0] frame_cnt_q;
   logic [3:0] offset_q;
   logic [4:0] spd_sum;

   always_ff @(posedge vga_clk) begin
      if (clr) begin
         frame_cnt_q <= '0;
         offset_q    <= '0;
      end else begin
         if (frame_tick_q) frame_cnt_q <= frame_cnt_q + 8'd1;
         if (load_ok)
            offset_q <= '0;
         else if (frame_tick_q && frame_cnt_q == 8'hFF && offset_q != 4'd15)
            offset_q <= offset_q + 4'd1;
      end
   end

   assign spd_sum = {1'b0, speed} + {1'b0, offset_q};
   assign eff_spd = !run ? 4'd0 : (spd_sum > 5'd15) ? 4'd15 : spd_sum[3:0];
`else
   assign eff_spd = run ? speed : 4'd0;
`endif

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      shift_d = shift_q;
      err_d   = err_q;
      rot_en  = 1'b0;
      // A frame start while still working on the previous one is dropped.
      if (start && state_q != S_ACTIVE) err_d = 1'b1;
      case (state_q)
         S_ACTIVE: begin
            wait_d = '0;
            if (start) state_d = S_UPD;
         end
         S_UPD: begin
            if (upd.upd_done || wait_q == CNT_W'(TIMEOUT - 1)) begin
               if (!upd.upd_done) err_d = 1'b1;
               // Shift amount is frozen here so speed changes mid-shift are harmless.
               shift_d = eff_spd;
               state_d = (eff_spd == 4'd0) ? S_ACTIVE : S_SHIFT;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         S_SHIFT: begin
            rot_en  = 1'b1;
            shift_d = shift_q - 4'd1;
            if (shift_q == 4'd1) state_d = S_ACTIVE;
         end
         default: state_d = S_ACTIVE;
      endcase
   end

   always_ff @(posedge vga_clk) begin
      if (clr) begin
         state_q      <= S_ACTIVE;
         vs_q         <= 1'b1;
         frame_tick_q <= 1'b0;
         err_q        <= 1'b0;
         wait_q       <= '0;
         shift_q      <= '0;
      end else begin
         state_q      <= state_d;
         vs_q         <= vs;
         frame_tick_q <= start;
         err_q        <= err_d;
         wait_q       <= wait_d;
         shift_q      <= shift_d;
      end
   end

   vga_ground_rot u_rot (
      .clk_i          (vga_clk),
      .clr_i          (clr),
      .load_i         (load_ok),
      .load_pattern_i (load_pattern),
      .rot_i          (rot_en),
      .px_o           (px_ground),
      .pos_o          (scroll_pos)
   );

   assign upd.upd_req = (state_q == S_UPD);
   assign frame_tick  = frame_tick_q;
   assign busy        = (state_q != S_ACTIVE);
   assign err         = err_q;
   assign dbg_state_o = state_q;

endmodule
